// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Port identifiers double as the round-robin history encoding.
package mem_arb_pkg;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  typedef struct packed {
    port_e port;
    logic  is_read;
    logic  err;
  } resp_t;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side bundle of the arbiter.
// slave is the arbiter's view; master is the core/memory environment's view.
interface mem_arb_if #(
  parameter int NUM_MEM    = 5,
  parameter int REG_WIDTH  = 32,
  parameter int MEM_SELECT = $clog2(NUM_MEM),
  parameter int CNT_WIDTH  = 16
);

  logic                  if_req;
  logic [MEM_SELECT-1:0] if_addr;
  logic                  d_req;
  logic [MEM_SELECT-1:0] d_addr;
  logic                  d_we;
  logic [REG_WIDTH-1:0]  d_wdata;
  logic                  if_gnt;
  logic                  d_gnt;
  logic                  if_rvalid;
  logic                  d_rvalid;
  logic                  if_err;
  logic                  d_err;
  logic [REG_WIDTH-1:0]  rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [MEM_SELECT-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_wdata;
  logic [REG_WIDTH-1:0]  mem_rdata;
  logic [CNT_WIDTH-1:0]  if_stall_cnt;
  logic [CNT_WIDTH-1:0]  d_stall_cnt;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    output if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, if_stall_cnt, d_stall_cnt
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
    input  if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, if_stall_cnt, d_stall_cnt
  );

endinterface

// File: rtl/mem_arb_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is fetch, bit 1 is data.
// Grants are combinational; last_gnt only moves when something is granted.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_valid
);

  port_e last_gnt;

  // On a conflict the port that did not win last time goes first
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) begin
        gnt = (last_gnt == PORT_IF) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  assign gnt_valid = |gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= PORT_IF;
    end else if (gnt[1]) begin
      last_gnt <= PORT_D;
    end else if (gnt[0]) begin
      last_gnt <= PORT_IF;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Shares one single-port memory between instruction fetch and load/store.
// One grant per cycle, one-cycle read response, out-of-range flagging, stall counters.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int NUM_MEM    = 5,
  parameter int REG_WIDTH  = 32,
  parameter int MEM_SELECT = $clog2(NUM_MEM),
  parameter int CNT_WIDTH  = 16
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);

  localparam logic [MEM_SELECT:0]  ADDR_LIMIT = (MEM_SELECT+1)'(NUM_MEM);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  logic [1:0]            gnt;
  logic                  gnt_valid;
  logic                  sel_d;
  logic [MEM_SELECT-1:0] sel_addr;
  logic                  sel_err;
  logic                  sel_we;
  resp_t                 resp;
  logic                  resp_valid;
  logic                  resp_live;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({bus.d_req, bus.if_req}),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  assign bus.if_gnt = gnt[0];
  assign bus.d_gnt  = gnt[1];

  assign sel_d    = gnt[1];
  assign sel_addr = sel_d ? bus.d_addr : bus.if_addr;
  assign sel_err  = ({1'b0, sel_addr} >= ADDR_LIMIT);
  assign sel_we   = sel_d & bus.d_we;

  // Out-of-range accesses are still granted but never reach the memory
  assign bus.mem_en    = gnt_valid & ~sel_err;
  assign bus.mem_we    = bus.mem_en & sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = bus.d_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp       <= '0;
    end else begin
      resp_valid <= gnt_valid;
      if (gnt_valid) begin
        resp <= '{port: sel_d ? PORT_D : PORT_IF, is_read: ~sel_we, err: sel_err};
      end
    end
  end

  // A response sitting in the register when reset arrives is dropped immediately
  assign resp_live     = resp_valid & ~rst;
  assign bus.if_rvalid = resp_live & resp.is_read & (resp.port == PORT_IF);
  assign bus.d_rvalid  = resp_live & resp.is_read & (resp.port == PORT_D);
  assign bus.if_err    = resp_live & resp.err & (resp.port == PORT_IF);
  assign bus.d_err     = resp_live & resp.err & (resp.port == PORT_D);
  assign bus.rdata     = (resp_live & resp.is_read & ~resp.err) ? bus.mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.if_stall_cnt <= '0;
    end else if (bus.if_req && !gnt[0] && bus.if_stall_cnt != CNT_MAX) begin
      bus.if_stall_cnt <= bus.if_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.d_stall_cnt <= '0;
    end else if (bus.d_req && !gnt[1] && bus.d_stall_cnt != CNT_MAX) begin
      bus.d_stall_cnt <= bus.d_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural 5-word memory,
// plus a second instance with 2-bit counters to exercise saturation.
module tb_mem_arb;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [31:0] mem [0:7];

  mem_arb_if #(.NUM_MEM(5), .REG_WIDTH(32), .CNT_WIDTH(16)) bus ();
  mem_arb_if #(.NUM_MEM(5), .REG_WIDTH(32), .CNT_WIDTH(2))  sbus ();

  mem_arb #(.NUM_MEM(5), .REG_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_arb #(.NUM_MEM(5), .REG_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory: data appears the cycle after mem_en
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  assign sbus.mem_rdata = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [2:0] ifAddr,
                               input logic dReq, input logic dWe,
                               input logic [2:0] dAddr, input logic [31:0] dWdata);
    bus.if_req  = ifReq;
    bus.if_addr = ifAddr;
    bus.d_req   = dReq;
    bus.d_we    = dWe;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[0] = 32'h11;
    mem[1] = 32'h2;
    sbus.if_req = 1'b0; sbus.if_addr = 3'd0;
    sbus.d_req  = 1'b0; sbus.d_addr  = 3'd1;
    sbus.d_we   = 1'b0; sbus.d_wdata = 32'h0;

    // Reset with a fetch request held: nothing granted, nothing counted
    rst = 1'b1;
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();
    checkOutput("rst_if_gnt", 32'(bus.if_gnt), 32'h0);
    checkOutput("rst_mem_en", 32'(bus.mem_en), 32'h0);
    checkOutput("rst_if_cnt", 32'(bus.if_stall_cnt), 32'h0);
    checkOutput("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    checkOutput("rst_rdata", bus.rdata, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 32'h0);
    tick();

    // Fetch-only read of addr 1
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 32'h0);
    checkOutput("f1_if_gnt", 32'(bus.if_gnt), 32'h1);
    checkOutput("f1_mem_en", 32'(bus.mem_en), 32'h1);
    checkOutput("f1_mem_addr", 32'(bus.mem_addr), 32'h1);
    tick();
    checkOutput("f1_if_rvalid", 32'(bus.if_rvalid), 32'h1);
    checkOutput("f1_rdata", bus.rdata, 32'h2);
    checkOutput("f1_if_err", 32'(bus.if_err), 32'h0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 32'h0);

    // Continuous conflict: D, IF, D, IF, D, IF
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 3'd1, 32'h0);
      checkOutput($sformatf("rr_d_gnt%0d", i), 32'(bus.d_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("rr_if_gnt%0d", i), 32'(bus.if_gnt), (i % 2 == 1) ? 32'h1 : 32'h0);
      tick();
    end
    checkOutput("rr_if_cnt", 32'(bus.if_stall_cnt), 32'd3);
    checkOutput("rr_d_cnt", 32'(bus.d_stall_cnt), 32'd3);
    checkOutput("rr_if_rvalid", 32'(bus.if_rvalid), 32'h1);
    checkOutput("rr_rdata", bus.rdata, 32'h11);

    // Data write 7 to addr 3, fetch of addr 3 the next cycle
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 3'd3, 32'h7);
    checkOutput("wr_d_gnt", 32'(bus.d_gnt), 32'h1);
    checkOutput("wr_mem_we", 32'(bus.mem_we), 32'h1);
    checkOutput("wr_mem_addr", 32'(bus.mem_addr), 32'h3);
    tick();
    checkOutput("wr_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    checkOutput("wr_d_err", 32'(bus.d_err), 32'h0);
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 32'h0);
    checkOutput("rd3_if_gnt", 32'(bus.if_gnt), 32'h1);
    checkOutput("rd3_mem_we", 32'(bus.mem_we), 32'h0);
    tick();
    checkOutput("rd3_if_rvalid", 32'(bus.if_rvalid), 32'h1);
    checkOutput("rd3_rdata", bus.rdata, 32'h7);

    // Out-of-range data read of addr 6
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 3'd6, 32'h0);
    checkOutput("oor_d_gnt", 32'(bus.d_gnt), 32'h1);
    checkOutput("oor_mem_en", 32'(bus.mem_en), 32'h0);
    tick();
    checkOutput("oor_d_rvalid", 32'(bus.d_rvalid), 32'h1);
    checkOutput("oor_d_err", 32'(bus.d_err), 32'h1);
    checkOutput("oor_rdata", bus.rdata, 32'h0);

    // Out-of-range write to addr 7: err pulse only
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b1, 3'd7, 32'h55);
    checkOutput("oorw_d_gnt", 32'(bus.d_gnt), 32'h1);
    checkOutput("oorw_mem_en", 32'(bus.mem_en), 32'h0);
    tick();
    checkOutput("oorw_d_err", 32'(bus.d_err), 32'h1);
    checkOutput("oorw_d_rvalid", 32'(bus.d_rvalid), 32'h0);

    // Data read granted, then reset the following cycle
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0, 3'd1, 32'h0);
    checkOutput("rr2_d_gnt", 32'(bus.d_gnt), 32'h1);
    tick();
    rst = 1'b1;
    applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 3'd1, 32'h0);
    checkOutput("rr2_rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    checkOutput("rr2_rst_d_gnt", 32'(bus.d_gnt), 32'h0);
    tick();
    checkOutput("rr2_after_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    checkOutput("rr2_after_if_cnt", 32'(bus.if_stall_cnt), 32'h0);
    checkOutput("rr2_after_d_cnt", 32'(bus.d_stall_cnt), 32'h0);
    rst = 1'b0;
    applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 3'd1, 32'h0);
    checkOutput("post_rst_d_first", 32'(bus.d_gnt), 32'h1);
    checkOutput("post_rst_if_wait", 32'(bus.if_gnt), 32'h0);
    tick();
    checkOutput("post_rst_if_cnt", 32'(bus.if_stall_cnt), 32'h1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 32'h0);

    // 2-bit counters: 5 stalls per port must saturate at 3, not wrap to 1
    sbus.if_req = 1'b1;
    sbus.d_req  = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("sat_if_cnt", 32'(sbus.if_stall_cnt), 32'd3);
    checkOutput("sat_d_cnt", 32'(sbus.d_stall_cnt), 32'd3);
    sbus.if_req = 1'b0;
    sbus.d_req  = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
